mpuf_eval_ctrl: RTL and testbench

MPUF_EVAL_CTRL -- requirements
Module: mpuf_eval_ctrl

---
 rtl/mpuf_eval_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mpuf_eval_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpuf_eval_ctrl.sv
// ---------------------------------------------------------------------------
// mpuf_eval_ctrl
//
// Evaluation controller for a multi-lane PUF. For each accepted request it
// latches an optionally masked challenge. It then runs REPS repetitions of
// clear -> settle -> sample and counts the ones seen on every lane. At the
// end it majority-votes each lane and flags any lane whose samples disagreed.
//
// Ports:
//   clk       in   single rising-edge clock
//   clr       in   asynchronous active-low reset
//   start     in   evaluation request, honoured only while idle
//   chal_in   in   [CW] raw challenge
//   mask_en   in   selects chal_in ^ mask instead of chal_in
//   mask      in   [CW] challenge XOR mask
//   busy      out  high in every state except IDLE
//   done      out  one-cycle completion pulse
//   resp      out  [NL] majority-voted response, held until the next vote
//   unstable  out  [NL] lane saw both 0 and 1 across the repetitions
//   puf_clr   out  active-high clear to the PUF lanes
//   puf_chal  out  [CW] challenge presented to the lanes
//   puf_resp  in   [NL] raw lane outputs
// ---------------------------------------------------------------------------
module mpuf_eval_ctrl #(
  parameter int CW     = 32,
  parameter int NL     = 32,
  parameter int CLRW   = 2,
  parameter int SETTLE = 4,
  parameter int REPS   = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [CW-1:0] chal_in,
  input  logic          mask_en,
  input  logic [CW-1:0] mask,
  output logic          busy,
  output logic          done,
  output logic [NL-1:0] resp,
  output logic [NL-1:0] unstable,
  output logic          puf_clr,
  output logic [CW-1:0] puf_chal,
  input  logic [NL-1:0] puf_resp
);

  // An even repetition count has no strict majority, and zero-length
  // clear or settle phases would collapse the timing.
  if ((REPS < 1) || ((REPS % 2) == 0) || (CLRW < 1) || (SETTLE < 1)) begin : g_bad_params
    $fatal(1, "mpuf_eval_ctrl: REPS must be odd and >=1, CLRW and SETTLE must be >=1");
  end

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_VOTE   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // One phase counter is shared by CLEAR and SETTLE, so it is sized for
  // the longer of the two.
  localparam int PMAX = (CLRW > SETTLE) ? CLRW : SETTLE;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int RW   = $clog2(REPS + 1);
  localparam int CNTW = $clog2(REPS + 1);

  localparam logic [PW-1:0]   CLR_LAST = PW'(CLRW - 1);
  localparam logic [PW-1:0]   SET_LAST = PW'(SETTLE - 1);
  localparam logic [RW-1:0]   REP_LAST = RW'(REPS - 1);
  localparam logic [CNTW-1:0] HALF     = CNTW'(REPS / 2);
  localparam logic [CNTW-1:0] FULL     = CNTW'(REPS);

  logic [2:0]      state;
  logic [PW-1:0]   phase_cnt;
  logic [RW-1:0]   rep_cnt;
  logic [CNTW-1:0] lane_cnt [NL];

  logic accept;
  assign accept = (state == S_IDLE) && start;

  // Status outputs are decoded straight from the state. The state register
  // resets to IDLE, so all three of them are low during reset.
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign puf_clr = (state == S_CLEAR);

  // Sequencer: the phase counter times CLEAR and SETTLE, and the repetition
  // counter decides after each SAMPLE whether to loop or to vote.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_IDLE;
      phase_cnt <= '0;
      rep_cnt   <= '0;
      puf_chal  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            puf_chal  <= mask_en ? (chal_in ^ mask) : chal_in;
            phase_cnt <= '0;
            rep_cnt   <= '0;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (phase_cnt == CLR_LAST) begin
            phase_cnt <= '0;
            state     <= S_SETTLE;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        S_SETTLE: begin
          if (phase_cnt == SET_LAST) begin
            phase_cnt <= '0;
            state     <= S_SAMPLE;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        S_SAMPLE: begin
          if (rep_cnt == REP_LAST) begin
            state <= S_VOTE;
          end else begin
            rep_cnt <= rep_cnt + RW'(1);
            state   <= S_CLEAR;
          end
        end
        S_VOTE:  state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-lane ones counters. They are cleared on acceptance as well as on
  // reset, so an aborted evaluation can never leak counts into the next one.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NL; i++) lane_cnt[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NL; i++) lane_cnt[i] <= '0;
    end else if (state == S_SAMPLE) begin
      for (int i = 0; i < NL; i++) begin
        if (puf_resp[i]) lane_cnt[i] <= lane_cnt[i] + CNTW'(1);
      end
    end
  end

  // Majority vote and disagreement flags. These are registered once per
  // evaluation and held until the next vote.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      resp     <= '0;
      unstable <= '0;
    end else if (state == S_VOTE) begin
      for (int i = 0; i < NL; i++) begin
        resp[i]     <= (lane_cnt[i] > HALF);
        unstable[i] <= (lane_cnt[i] != '0) && (lane_cnt[i] != FULL);
      end
    end
  end

endmodule

// File: tb/tb_mpuf_eval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mpuf_eval_ctrl
//
// Self-checking bench for mpuf_eval_ctrl. It holds two instances:
//   u_dut   : default parameters (CW=NL=32, CLRW=2, SETTLE=4, REPS=5)
//   u_small : CW=NL=8, CLRW=1, SETTLE=1, REPS=1
// Lane samples are fed one value per repetition window. Expected responses
// come from a per-lane popcount model over those samples.
// ---------------------------------------------------------------------------
module tb_mpuf_eval_ctrl;

  localparam int REP_CYC = 7;   // CLRW + SETTLE + 1 with defaults
  localparam int LAT     = 37;  // 5*7 + 2
  localparam int PERIOD  = 38;  // LAT plus one IDLE cycle

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] chal_in = '0;
  logic        mask_en = 1'b0;
  logic [31:0] mask = '0;
  logic [31:0] puf_resp = '0;
  logic        busy, done, puf_clr;
  logic [31:0] resp, unstable, puf_chal;

  logic        s_start = 1'b0;
  logic [7:0]  s_chal_in = '0;
  logic        s_mask_en = 1'b0;
  logic [7:0]  s_mask = '0;
  logic [7:0]  s_puf_resp = '0;
  logic        s_busy, s_done, s_puf_clr;
  logic [7:0]  s_resp, s_unstable, s_puf_chal;

  int total = 0;
  int bad   = 0;

  logic [31:0] samp [5];

  always #5 clk = ~clk;

  mpuf_eval_ctrl u_dut (
    .clk(clk), .clr(clr), .start(start), .chal_in(chal_in),
    .mask_en(mask_en), .mask(mask), .busy(busy), .done(done),
    .resp(resp), .unstable(unstable), .puf_clr(puf_clr),
    .puf_chal(puf_chal), .puf_resp(puf_resp)
  );

  mpuf_eval_ctrl #(.CW(8), .NL(8), .CLRW(1), .SETTLE(1), .REPS(1)) u_small (
    .clk(clk), .clr(clr), .start(s_start), .chal_in(s_chal_in),
    .mask_en(s_mask_en), .mask(s_mask), .busy(s_busy), .done(s_done),
    .resp(s_resp), .unstable(s_unstable), .puf_clr(s_puf_clr),
    .puf_chal(s_puf_chal), .puf_resp(s_puf_resp)
  );

  // Majority of five samples per lane; a lane is unstable unless all agree.
  function automatic void model(output logic [31:0] r, output logic [31:0] u);
    for (int i = 0; i < 32; i++) begin
      int c;
      c = 0;
      for (int k = 0; k < 5; k++) c += int'(samp[k][i]);
      r[i] = (c >= 3);
      u[i] = (c != 0) && (c != 5);
    end
  endfunction

  // One start pulse on the default instance. It feeds samp[rep] during each
  // repetition window and watches puf_clr. It returns the count of falling
  // edges from acceptance up to the first one that sees done high.
  task automatic run_eval(output int lat, output logic [31:0] r_obs, output logic [31:0] u_obs,
                          output int clr_hi, output int clr_rises);
    int   n;
    logic prev;
    lat = -1; r_obs = '0; u_obs = '0; clr_hi = 0; clr_rises = 0; prev = 1'b0;
    @(negedge clk);
    start = 1'b1;
    puf_resp = samp[0];
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (lat < 0 && n <= 60) begin
      if (puf_clr) begin
        clr_hi++;
        if (!prev) clr_rises++;
      end
      prev = puf_clr;
      if ((n - 1) / REP_CYC < 5) puf_resp = samp[(n - 1) / REP_CYC];
      if (done) begin
        lat = n; r_obs = resp; u_obs = unstable;
      end else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset;
    clr = 1'b0;
    #3;
    total++;
    if ({busy, done, puf_clr} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_status: got %b want 000", {busy, done, puf_clr});
    end
    total++;
    if (resp !== '0 || unstable !== '0) begin
      bad++; $display("[TB] FAIL reset_resp: got resp=%h unstable=%h want 0", resp, unstable);
    end
    total++;
    if (puf_chal !== '0) begin
      bad++; $display("[TB] FAIL reset_chal: got %h want 0", puf_chal);
    end
    total++;
    if ({s_busy, s_done, s_puf_clr, s_resp, s_unstable, s_puf_chal} !== '0) begin
      bad++; $display("[TB] FAIL reset_small: got busy=%b done=%b resp=%h want all 0", s_busy, s_done, s_resp);
    end
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency;
    int lat, ch, cr;
    logic [31:0] r, u;
    for (int k = 0; k < 5; k++) samp[k] = 32'hA5A5_A5A5;
    run_eval(lat, r, u, ch, cr);
    total++;
    if (lat !== LAT) begin bad++; $display("[TB] FAIL latency: got %0d want %0d", lat, LAT); end
    total++;
    if (r !== 32'hA5A5_A5A5) begin bad++; $display("[TB] FAIL latency_resp: got %h want a5a5a5a5", r); end
    total++;
    if (u !== '0) begin bad++; $display("[TB] FAIL latency_unstable: got %h want 0", u); end
    total++;
    if (ch !== 10) begin bad++; $display("[TB] FAIL clr_cycles: got %0d want 10", ch); end
    total++;
    if (cr !== 5) begin bad++; $display("[TB] FAIL clr_pulses: got %0d want 5", cr); end
  endtask

  task automatic test_mask;
    int lat, ch, cr;
    logic [31:0] r, u;
    chal_in = 32'hFFFF_0000; mask = 32'h0F0F_0F0F; mask_en = 1'b1;
    run_eval(lat, r, u, ch, cr);
    chal_in = 32'h1234_5678; mask_en = 1'b0;
    @(negedge clk);
    total++;
    if (puf_chal !== 32'hF0F0_0F0F) begin bad++; $display("[TB] FAIL mask_on: got %h want f0f00f0f", puf_chal); end
    chal_in = 32'hFFFF_0000;
    run_eval(lat, r, u, ch, cr);
    total++;
    if (puf_chal !== 32'hFFFF_0000) begin bad++; $display("[TB] FAIL mask_off: got %h want ffff0000", puf_chal); end
    total++;
    if (lat !== LAT) begin bad++; $display("[TB] FAIL mask_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_lanes;
    int lat, ch, cr;
    logic [31:0] r, u, er, eu;
    logic [4:0] l0, l1;
    l0 = 5'b01011;  // reps 0..4 -> 1,1,0,1,0
    l1 = 5'b10100;  // reps 0..4 -> 0,0,1,0,1
    for (int k = 0; k < 5; k++) samp[k] = {30'd0, l1[k], l0[k]};
    model(er, eu);
    run_eval(lat, r, u, ch, cr);
    total++;
    if (r[1:0] !== 2'b01) begin bad++; $display("[TB] FAIL lanes_resp: got %b want 01", r[1:0]); end
    total++;
    if (u[1:0] !== 2'b11) begin bad++; $display("[TB] FAIL lanes_unstable: got %b want 11", u[1:0]); end
    total++;
    if (r !== er || u !== eu) begin
      bad++; $display("[TB] FAIL lanes_model: got %h/%h want %h/%h", r, u, er, eu);
    end
  endtask

  task automatic test_random;
    int lat, ch, cr;
    logic [31:0] r, u, er, eu, base, ec;
    for (int t = 0; t < 6; t++) begin
      base = $urandom;
      for (int k = 0; k < 5; k++) samp[k] = base ^ ($urandom & $urandom & $urandom);
      chal_in = $urandom; mask = $urandom; mask_en = 1'($urandom_range(0, 1));
      ec = mask_en ? (chal_in ^ mask) : chal_in;
      model(er, eu);
      run_eval(lat, r, u, ch, cr);
      total++;
      if (r !== er) begin bad++; $display("[TB] FAIL rand_resp[%0d]: got %h want %h", t, r, er); end
      total++;
      if (u !== eu) begin bad++; $display("[TB] FAIL rand_unstable[%0d]: got %h want %h", t, u, eu); end
      total++;
      if (puf_chal !== ec) begin bad++; $display("[TB] FAIL rand_chal[%0d]: got %h want %h", t, puf_chal, ec); end
    end
  endtask

  task automatic test_ignore_start;
    int n, ndone, first, p0, p1;
    p0 = $urandom_range(2, 15);
    p1 = $urandom_range(16, 33);
    for (int k = 0; k < 5; k++) samp[k] = 32'h0000_FFFF;
    puf_resp = samp[0];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; first = -1;
    for (n = 1; n <= 90; n++) begin
      if (done) begin
        ndone++;
        if (first < 0) first = n;
      end
      start = (n == p0 || n == p1 || n == p0 + 1) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (ndone !== 1) begin bad++; $display("[TB] FAIL ignore_done_count: got %0d want 1", ndone); end
    total++;
    if (first !== LAT) begin bad++; $display("[TB] FAIL ignore_latency: got %0d want %0d", first, LAT); end
  endtask

  task automatic test_back_to_back;
    int n, cnt;
    int t [3];
    for (int k = 0; k < 5; k++) samp[k] = 32'h3C3C_C3C3;
    puf_resp = samp[0];
    t[0] = -1; t[1] = -1; t[2] = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    cnt = 0;
    n = 1;
    while (cnt < 3 && n <= 200) begin
      if (done) begin
        t[cnt] = n;
        cnt++;
      end
      if (cnt == 3) start = 1'b0;
      else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    total++;
    if (t[0] !== LAT) begin bad++; $display("[TB] FAIL b2b_first: got %0d want %0d", t[0], LAT); end
    total++;
    if (t[1] - t[0] !== PERIOD) begin bad++; $display("[TB] FAIL b2b_gap1: got %0d want %0d", t[1] - t[0], PERIOD); end
    total++;
    if (t[2] - t[1] !== PERIOD) begin bad++; $display("[TB] FAIL b2b_gap2: got %0d want %0d", t[2] - t[1], PERIOD); end
    total++;
    if (resp !== 32'h3C3C_C3C3) begin bad++; $display("[TB] FAIL b2b_resp: got %h want 3c3cc3c3", resp); end
    n = 0;
    while (busy && n < 10) begin @(negedge clk); n++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_abort;
    int lat, ch, cr, ndone;
    logic [31:0] r, u, er, eu;
    for (int k = 0; k < 5; k++) samp[k] = 32'hFFFF_FFFF;
    chal_in = 32'hDEAD_BEEF; mask_en = 1'b0;
    puf_resp = samp[0];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    clr = 1'b0;
    #1;
    total++;
    if ({busy, done, puf_clr} !== 3'b000) begin
      bad++; $display("[TB] FAIL abort_status: got %b want 000", {busy, done, puf_clr});
    end
    total++;
    if (resp !== '0 || unstable !== '0 || puf_chal !== '0) begin
      bad++; $display("[TB] FAIL abort_outputs: got resp=%h unstable=%h chal=%h want 0", resp, unstable, puf_chal);
    end
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 2) clr = 1'b1;
      if (done) ndone++;
    end
    total++;
    if (ndone !== 0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d want 0", ndone); end
    // Each lane is high in exactly two repetitions. Leftover partial counts
    // from the aborted run would push these lanes over the majority.
    for (int k = 0; k < 5; k++) samp[k] = (k < 2) ? 32'hFFFF_FFFF : 32'h0000_0000;
    model(er, eu);
    run_eval(lat, r, u, ch, cr);
    total++;
    if (r !== er || r !== 32'h0) begin bad++; $display("[TB] FAIL abort_resp: got %h want %h", r, er); end
    total++;
    if (u !== eu) begin bad++; $display("[TB] FAIL abort_unstable: got %h want %h", u, eu); end
  endtask

  task automatic test_reps1;
    int n, lat;
    logic [7:0] exp_r, val, r, u;
    for (int t = 0; t < 3; t++) begin
      lat = -1; exp_r = 'x; r = '0; u = '0;
      @(negedge clk);
      s_start = 1'b1;
      s_puf_resp = 8'($urandom);
      @(negedge clk);
      s_start = 1'b0;
      n = 1;
      while (lat < 0 && n <= 20) begin
        if (s_done) begin
          lat = n; r = s_resp; u = s_unstable;
        end else begin
          val = 8'($urandom);
          s_puf_resp = val;
          if (n == 3) exp_r = val;
          @(negedge clk);
          n++;
        end
      end
      total++;
      if (lat !== 5) begin bad++; $display("[TB] FAIL r1_latency[%0d]: got %0d want 5", t, lat); end
      total++;
      if (r !== exp_r) begin bad++; $display("[TB] FAIL r1_resp[%0d]: got %h want %h", t, r, exp_r); end
      total++;
      if (u !== 8'h00) begin bad++; $display("[TB] FAIL r1_unstable[%0d]: got %h want 00", t, u); end
    end
  endtask

  initial begin
    $display("[TB] starting mpuf_eval_ctrl bench");
    test_reset;
    test_latency;
    test_mask;
    test_lanes;
    test_random;
    test_ignore_start;
    test_back_to_back;
    test_abort;
    test_reps1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
